// File: rtl/ysyx_22040759_inst_encoder.sv
// RV64I instruction encoder: packs op/register/immediate fields into a 32-bit word behind a 2-entry output FIFO.
// Define ENC_RANGE_CHECK_EN to flag immediates that do not fit their format; otherwise only illegal ops set err.
module ysyx_22040759_inst_encoder #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] inst_cnt
);

    typedef enum logic [3:0] {
        OP_ADDI  = 4'd0,
        OP_AUIPC = 4'd1,
        OP_LUI   = 4'd2,
        OP_JAL   = 4'd3,
        OP_JALR  = 4'd4,
        OP_SD    = 4'd5,
        OP_LD    = 4'd6,
        OP_ADD   = 4'd7,
        OP_ADDIW = 4'd8,
        OP_SUB   = 4'd9,
        OP_SLTIU = 4'd10,
        OP_BNE   = 4'd11,
        OP_BEQ   = 4'd12
    } op_e;

    typedef enum logic [2:0] {
        FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_ILL
    } fmt_e;

    fmt_e        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        rng_bad;

    always_comb begin
        fmt = FMT_ILL;
        opc = 7'b0010011;
        f3  = 3'b000;
        f7  = 7'b0000000;
        case (op_e'(in_op))
            OP_ADDI:  begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b000; end
            OP_SLTIU: begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b011; end
            OP_ADDIW: begin fmt = FMT_I; opc = 7'b0011011; f3 = 3'b000; end
            OP_JALR:  begin fmt = FMT_I; opc = 7'b1100111; f3 = 3'b000; end
            OP_LD:    begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b011; end
            OP_SD:    begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b011; end
            OP_AUIPC: begin fmt = FMT_U; opc = 7'b0010111; end
            OP_LUI:   begin fmt = FMT_U; opc = 7'b0110111; end
            OP_JAL:   begin fmt = FMT_J; opc = 7'b1101111; end
            OP_ADD:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; end
            OP_SUB:   begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
            OP_BEQ:   begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b000; end
            OP_BNE:   begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b001; end
            default:  fmt = FMT_ILL;
        endcase
    end

    // Out-of-range immediates are still truncated into the word; only err reports them.
    always_comb begin
        enc_inst = 32'h0000_0013;
        case (fmt)
            FMT_I:   enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            FMT_S:   enc_inst = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            FMT_B:   enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                                 in_imm[4:1], in_imm[11], opc};
            FMT_U:   enc_inst = {in_imm[31:12], in_rd, opc};
            FMT_J:   enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
            FMT_R:   enc_inst = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            default: enc_inst = 32'h0000_0013;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic fits12, fits13, fits21, fits32;

    assign fits12 = (in_imm == {{52{in_imm[11]}}, in_imm[11:0]});
    assign fits13 = (in_imm == {{51{in_imm[12]}}, in_imm[12:0]});
    assign fits21 = (in_imm == {{43{in_imm[20]}}, in_imm[20:0]});
    assign fits32 = (in_imm == {{32{in_imm[31]}}, in_imm[31:0]});

    always_comb begin
        rng_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: rng_bad = !fits12;
            FMT_B:        rng_bad = in_imm[0] || !fits13;
            FMT_J:        rng_bad = in_imm[0] || !fits21;
            FMT_U:        rng_bad = (|in_imm[11:0]) || !fits32;
            default:      rng_bad = 1'b0;
        endcase
    end
`else
    logic unused_imm_hi;

    assign unused_imm_hi = ^in_imm[63:32];
    assign rng_bad       = 1'b0;
`endif

    assign enc_err = (fmt == FMT_ILL) || rng_bad;

    logic [32:0]      mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    // in_ready depends only on occupancy, so a full FIFO never accepts in a pop cycle.
    assign in_ready  = (occ_q < 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_inst  = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign out_err   = out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
    assign inst_cnt  = cnt_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = pop  ? cnt_q + CNT_W'(1) : cnt_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {enc_err, enc_inst};
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_inst_encoder.sv
// Self-checking bench for ysyx_22040759_inst_encoder: directed encodings, backpressure, same-cycle push/pop,
// asynchronous reset and randomized traffic against an arithmetic reference model plus an expected-entry queue.
module tb_ysyx_22040759_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [31:0] inst_cnt;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [31:0] exp_cnt;

`ifdef ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        int          op;
        int          rd;
        int          rs1;
        int          rs2;
        longint      imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    ysyx_22040759_inst_encoder #(.CNT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_err  (out_err),
        .inst_cnt (inst_cnt)
    );

    always #5 clk = ~clk;

    // Reference encoder: fields placed by shift-and-mask, ranges checked as signed integer intervals.
    function automatic logic [32:0] ref_enc(input int op, input int rd, input int rs1, input int rs2,
                                            input longint imm);
        longint opc, f3, f7, w;
        int     fmt;
        bit     bad;
        longint r  = longint'(rd);
        longint s1 = longint'(rs1);
        longint s2 = longint'(rs2);
        f3 = 0; f7 = 0; opc = 0; fmt = 0;
        case (op)
            0:  begin fmt = 0; opc = 'h13; f3 = 0; end
            10: begin fmt = 0; opc = 'h13; f3 = 3; end
            8:  begin fmt = 0; opc = 'h1B; f3 = 0; end
            4:  begin fmt = 0; opc = 'h67; f3 = 0; end
            6:  begin fmt = 0; opc = 'h03; f3 = 3; end
            5:  begin fmt = 1; opc = 'h23; f3 = 3; end
            12: begin fmt = 2; opc = 'h63; f3 = 0; end
            11: begin fmt = 2; opc = 'h63; f3 = 1; end
            1:  begin fmt = 3; opc = 'h17; end
            2:  begin fmt = 3; opc = 'h37; end
            3:  begin fmt = 4; opc = 'h6F; end
            7:  begin fmt = 5; opc = 'h33; f7 = 0; end
            9:  begin fmt = 5; opc = 'h33; f7 = 'h20; end
            default: return {1'b1, 32'h0000_0013};
        endcase
        bad = 0;
        case (fmt)
            0: begin
                w = ((imm & 'hfff) << 20) | (s1 << 15) | (f3 << 12) | (r << 7) | opc;
                bad = !(imm >= -2048 && imm <= 2047);
            end
            1: begin
                w = (((imm >> 5) & 'h7f) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                    | ((imm & 'h1f) << 7) | opc;
                bad = !(imm >= -2048 && imm <= 2047);
            end
            2: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3f) << 25) | (s2 << 20) | (s1 << 15)
                    | (f3 << 12) | (((imm >> 1) & 'hf) << 8) | (((imm >> 11) & 1) << 7) | opc;
                bad = !(imm >= -4096 && imm <= 4095 && (imm & 1) == 0);
            end
            3: begin
                w = (imm & 'hffff_f000) | (r << 7) | opc;
                bad = !(imm >= -(64'sd1 << 31) && imm <= (64'sd1 << 31) - 1 && (imm & 'hfff) == 0);
            end
            4: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3ff) << 21) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 12) & 'hff) << 12) | (r << 7) | opc;
                bad = !(imm >= -(64'sd1 << 20) && imm <= (64'sd1 << 20) - 1 && (imm & 1) == 0);
            end
            default: begin
                w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (r << 7) | opc;
                bad = 0;
            end
        endcase
        if (!RC) bad = 0;
        return {bad, w[31:0]};
    endfunction

    // Drive one cycle of inputs, advance past the edge, then update the expected FIFO contents.
    task automatic step(input bit v, input int op, input int rd, input int rs1, input int rs2,
                        input longint imm, input bit ordy);
        bit acc, pp;
        in_valid  = v;
        in_op     = op[3:0];
        in_rd     = rd[4:0];
        in_rs1    = rs1[4:0];
        in_rs2    = rs2[4:0];
        in_imm    = imm;
        out_ready = ordy;
        acc = v && (exp_q.size() < 2);
        pp  = ordy && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (pp) begin
            void'(exp_q.pop_front());
            exp_cnt++;
        end
        if (acc) exp_q.push_back(ref_enc(op, rd, rs1, rs2, imm));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        exp_q.delete();
        exp_cnt = 0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || inst_cnt !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b inst=%h err=%b cnt=%0d want 0/0/0/0",
                     out_valid, out_inst, out_err, inst_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        vec_t v[$];
        v.push_back('{0,  1, 0, 0, 64'sd5,          32'h0050_0093, 1'b0});
        v.push_back('{2,  5, 0, 0, 64'sh1234_5000,  32'h1234_52B7, 1'b0});
        v.push_back('{3,  1, 0, 0, 64'sd8,          32'h0080_00EF, 1'b0});
        v.push_back('{12, 7, 1, 2, -64'sd4,         32'hFE20_8EE3, 1'b0});
        v.push_back('{5,  9, 1, 2, 64'sd8,          32'h0020_B423, 1'b0});
        v.push_back('{0,  1, 0, 0, 64'sd2048,       32'h8000_0093, RC});
        v.push_back('{12, 0, 1, 2, 64'sd3,          32'h0020_8163, RC});
        v.push_back('{14, 3, 4, 5, 64'sd77,         32'h0000_0013, 1'b1});
        v.push_back('{7,  3, 1, 2, 64'sd12345678,   32'h0020_81B3, 1'b0});
        v.push_back('{9,  3, 1, 2, -64'sd1,         32'h4020_81B3, 1'b0});
        v.push_back('{6,  3, 1, 0, 64'sd16,         32'h0100_B183, 1'b0});
        foreach (v[i]) begin
            step(1, v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm, 1);
            checks++;
            if (out_valid !== 1'b1 || out_inst !== v[i].inst || out_err !== v[i].err) begin
                errors++;
                $display("[TB] FAIL vector_%0d: got v=%b inst=%h err=%b want 1 %h %b",
                         i, out_valid, out_inst, out_err, v[i].inst, v[i].err);
            end
            checks++;
            if (inst_cnt !== 32'(i)) begin
                errors++;
                $display("[TB] FAIL vector_cnt_%0d: got %0d want %0d", i, inst_cnt, i);
            end
        end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || inst_cnt !== 32'(v.size())) begin
            errors++;
            $display("[TB] FAIL vectors_drain: got v=%b cnt=%0d want 0 %0d", out_valid, inst_cnt, v.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(1, 0, 1, 0, 0, 5, 0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_inst !== 32'h0050_0093) begin
            errors++;
            $display("[TB] FAIL bp_one: got r=%b v=%b inst=%h want 1 1 00500093", in_ready, out_valid, out_inst);
        end
        step(1, 2, 5, 0, 0, 64'sh1234_5000, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_full: got ready=%b want 0", in_ready);
        end
        step(1, 3, 1, 0, 0, 8, 0);
        checks++;
        if (in_ready !== 1'b0 || out_inst !== 32'h0050_0093 || out_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold: got r=%b inst=%h err=%b want 0 00500093 0", in_ready, out_inst, out_err);
        end
        step(1, 3, 1, 0, 0, 8, 1);
        checks++;
        if (out_inst !== 32'h1234_52B7 || in_ready !== 1'b1 || inst_cnt !== 32'd1) begin
            errors++;
            $display("[TB] FAIL bp_pop1: got inst=%h r=%b cnt=%0d want 123452B7 1 1", out_inst, in_ready, inst_cnt);
        end
        step(1, 3, 1, 0, 0, 8, 1);
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0080_00EF || inst_cnt !== 32'd2) begin
            errors++;
            $display("[TB] FAIL bp_pop2: got v=%b inst=%h cnt=%0d want 1 008000EF 2", out_valid, out_inst, inst_cnt);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || inst_cnt !== 32'd3) begin
            errors++;
            $display("[TB] FAIL bp_drain: got v=%b cnt=%0d want 0 3", out_valid, inst_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 0, 1, 0, 0, 1, 0);
        for (int i = 2; i < 8; i++) begin
            step(1, 0, i, 0, 0, i, 1);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_inst !== exp_q[0][31:0] || exp_q.size() != 1) begin
                errors++;
                $display("[TB] FAIL b2b_%0d: got v=%b r=%b inst=%h want 1 1 %h", i, out_valid, in_ready,
                         out_inst, exp_q[0][31:0]);
            end
            checks++;
            if (out_inst[11:7] !== 5'(i) || inst_cnt !== 32'(i - 1)) begin
                errors++;
                $display("[TB] FAIL b2b_order_%0d: got rd=%0d cnt=%0d want %0d %0d", i, out_inst[11:7],
                         inst_cnt, i, i - 1);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 0, 1, 0, 0, 5, 0);
        step(1, 0, 2, 0, 0, 6, 1);
        step(1, 0, 3, 0, 0, 7, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || inst_cnt !== 32'h0 || out_inst !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b cnt=%0d inst=%h want 0 0 0", out_valid, inst_cnt, out_inst);
        end
        exp_q.delete();
        exp_cnt = 0;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_release: got ready=%b want 1", in_ready);
        end
        step(1, 5, 0, 1, 2, 8, 0);
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0020_B423 || out_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_next: got v=%b inst=%h err=%b want 1 0020B423 0", out_valid, out_inst, out_err);
        end
    endtask

    task automatic test_random();
        longint imm;
        int     sel;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            checks++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2) || inst_cnt !== exp_cnt) begin
                errors++;
                $display("[TB] FAIL rnd_ctrl_%0d: got v=%b r=%b cnt=%0d want %b %b %0d", n, out_valid, in_ready,
                         inst_cnt, exp_q.size() > 0, exp_q.size() < 2, exp_cnt);
            end
            if (exp_q.size() > 0) begin
                checks++;
                if ({out_err, out_inst} !== exp_q[0]) begin
                    errors++;
                    $display("[TB] FAIL rnd_head_%0d: got err=%b inst=%h want %b %h", n, out_err, out_inst,
                             exp_q[0][32], exp_q[0][31:0]);
                end
            end
            sel = $urandom_range(0, 3);
            case (sel)
                0:       imm = longint'($urandom_range(0, 6000)) - 3000;
                1:       imm = longint'($signed($urandom)) & -64'sd4096;
                2:       imm = longint'($urandom_range(0, 1 << 22)) - (64'sd1 << 21);
                default: imm = {$urandom, $urandom};
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), imm, $urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
